// File: rtl/mmio_stream_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM encoding for the
// MMIO-to-stream bridge.
package mmio_stream_pkg;

  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_LEVEL_LSB = 8;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_RESP       = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with flush and fill level; one per output channel.
module stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Flush wins over everything; a push into a full FIFO needs a same-cycle pop.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mmio_stream_bridge.sv
// picorv32 native-bus slave exposing N_CHAN buffered valid/ready output streams
// with per-channel DATA/STATUS/CTRL registers.
module mmio_stream_bridge
  import mmio_stream_pkg::*;
#(
  parameter int          N_CHAN        = 4,
  parameter int          DATA_W        = 8,
  parameter int          DEPTH         = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
  parameter int          BLOCK_ON_FULL = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     hit,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [N_CHAN*DATA_W-1:0] out_data,
  output logic [N_CHAN-1:0]        out_last,
  output logic [N_CHAN-1:0]        out_valid,
  input  logic [N_CHAN-1:0]        out_ready
);
  localparam int LW = $clog2(DEPTH) + 1;

  state_t                    state;
  logic [31:0]               offset;
  logic [2:0]                ch;
  logic [3:0]                reg_ofs;
  logic                      is_write;
  logic                      decode;
  logic [DATA_W:0]           push_word;
  logic [N_CHAN-1:0]         full, empty, pop, push, flush, ovf, set_ovf, clr_ovf;
  logic [N_CHAN-1:0][LW-1:0] level;
  logic                      sel_full, sel_empty, sel_ovf;
  logic [LW-1:0]             sel_level;
  logic [31:0]               status_word;
  logic [31:0]               read_word;
  logic                      unused_bits;

  assign offset    = mem_addr - BASE_ADDR;
  assign hit       = mem_valid && (mem_addr >= BASE_ADDR) && (offset < 32'(N_CHAN * 16));
  assign ch        = offset[6:4];
  assign reg_ofs   = {offset[3:2], 2'b00};
  assign is_write  = |mem_wstrb;
  assign decode    = (state == ST_IDLE) && hit && !mem_ready;
  assign push_word = {mem_wdata[31], mem_wdata[DATA_W-1:0]};
  assign out_valid = ~empty;
  assign pop       = ~empty & out_ready;
  assign unused_bits = ^{offset[31:7], offset[1:0], mem_wdata};

  always_comb begin
    sel_full  = 1'b0;
    sel_empty = 1'b0;
    sel_ovf   = 1'b0;
    sel_level = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      if (ch == 3'(c)) begin
        sel_full  = full[c];
        sel_empty = empty[c];
        sel_ovf   = ovf[c];
        sel_level = level[c];
      end
    end
    status_word = '0;
    status_word[STAT_EMPTY] = sel_empty;
    status_word[STAT_FULL]  = sel_full;
    status_word[STAT_OVF]   = sel_ovf;
    status_word[STAT_LEVEL_LSB +: 8] = 8'(sel_level);
    read_word = (!is_write && reg_ofs == OFS_STATUS) ? status_word : '0;
  end

  // Per-channel side effects of the decode cycle and of a stalled DATA write.
  always_comb begin
    push    = '0;
    flush   = '0;
    set_ovf = '0;
    clr_ovf = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      if (ch == 3'(c)) begin
        if (decode && is_write && reg_ofs == OFS_DATA) begin
          push[c]    = !full[c];
          set_ovf[c] = full[c] && (BLOCK_ON_FULL == 0);
        end
        if (decode && is_write && reg_ofs == OFS_CTRL) begin
          flush[c]   = mem_wdata[CTRL_FLUSH];
          clr_ovf[c] = mem_wdata[CTRL_CLR_OVF];
        end
        if (state == ST_WAIT_SPACE && (!full[c] || pop[c])) push[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf <= '0;
    else         ovf <= (ovf & ~clr_ovf) | set_ovf;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (decode) begin
            mem_rdata <= read_word;
            if (is_write && reg_ofs == OFS_DATA && sel_full && BLOCK_ON_FULL != 0)
              state <= ST_WAIT_SPACE;
            else
              state <= ST_RESP;
          end
        end
        ST_WAIT_SPACE: if (|push) state <= ST_RESP;
        ST_RESP: begin
          mem_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
    logic [DATA_W:0] dout;

    stream_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push[gi]),
      .din    (push_word),
      .pop    (pop[gi]),
      .flush  (flush[gi]),
      .dout   (dout),
      .full   (full[gi]),
      .empty  (empty[gi]),
      .level  (level[gi])
    );

    assign out_data[gi*DATA_W +: DATA_W] = dout[DATA_W-1:0];
    assign out_last[gi] = dout[DATA_W];
  end

endmodule

// File: tb/tb_mmio_stream_bridge.sv
// Directed bench: one blocking-on-full bridge (a) and one dropping bridge (b).
module tb_mmio_stream_bridge;

  logic        clk;
  logic        resetn;
  logic        valid_a, valid_b;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        hit_a, hit_b, ready_a, ready_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  last_a, last_b, ov_a, ov_b, ordy_a, ordy_b;

  int n_assert = 0;
  int n_fail   = 0;
  int got0 = 0, got3 = 0;
  bit mon_en = 0;

  mmio_stream_bridge #(.BLOCK_ON_FULL(1)) dut_a (
    .clk(clk), .resetn(resetn), .mem_valid(valid_a), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .hit(hit_a), .mem_ready(ready_a),
    .mem_rdata(rdata_a), .out_data(data_a), .out_last(last_a),
    .out_valid(ov_a), .out_ready(ordy_a)
  );

  mmio_stream_bridge #(.BLOCK_ON_FULL(0)) dut_b (
    .clk(clk), .resetn(resetn), .mem_valid(valid_b), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .hit(hit_b), .mem_ready(ready_b),
    .mem_rdata(rdata_b), .out_data(data_b), .out_last(last_b),
    .out_valid(ov_b), .out_ready(ordy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus access; every access through here must answer exactly 2 cycles after valid.
  task automatic bus(input bit sel_b, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    addr = a; wdata = d; wstrb = s;
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel_b ? ready_b : ready_a) && lat < 50);
    rd = sel_b ? rdata_b : rdata_a;
    valid_a = 1'b0; valid_b = 1'b0;
    chk("latency", lat, 2);
    @(negedge clk);
    chk("ready_pulse", {31'd0, sel_b ? ready_b : ready_a}, 0);
    $display("bus %s addr=%h wdata=%h wstrb=%h rdata=%h lat=%0d",
             sel_b ? "b" : "a", a, d, s, rd, lat);
  endtask

  task automatic wr(input bit sel_b, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus(sel_b, a, d, 4'hF, rd);
  endtask

  task automatic rd_chk(input bit sel_b, input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    bus(sel_b, a, 32'h0, 4'h0, rd);
    chk(tag, rd, exp);
  endtask

  // Random consumer for channels 0 and 3: choose ready, then score the pop the next edge will take.
  always @(negedge clk) begin
    if (mon_en) begin
      ordy_a[0] = 1'($urandom_range(0, 1));
      ordy_a[3] = 1'($urandom_range(0, 1));
      if (ov_a[0] && ordy_a[0]) begin
        chk("ch0_data", {24'd0, data_a[7:0]}, 32'(8'h10 + got0));
        chk("ch0_last", {31'd0, last_a[0]}, {31'd0, got0 == 5});
        got0++;
      end
      if (ov_a[3] && ordy_a[3]) begin
        chk("ch3_data", {24'd0, data_a[31:24]}, 32'(8'hC0 + got3));
        chk("ch3_last", {31'd0, last_a[3]}, {31'd0, got3 == 5});
        got3++;
      end
      chk("no_leak", {28'd0, ov_a & 4'b0110}, 0);
    end
  end

  initial begin
    int seen;
    int k;
    resetn = 1'b0; valid_a = 0; valid_b = 0; addr = 0; wdata = 0; wstrb = 0;
    ordy_a = 4'b0; ordy_b = 4'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready_a}, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_valid", {28'd0, ov_a}, 0);
    chk("rst_data", data_a, 0);
    chk("rst_last", {28'd0, last_a}, 0);
    resetn = 1'b1;

    // STATUS ch0 after reset: empty only
    rd_chk(0, 32'h4000_0004, 32'h0000_0001, "status_ch0_reset");
    rd_chk(0, 32'h4000_000C, 32'h0, "unused_offset");

    // Single word with last to ch2
    wr(0, 32'h4000_0020, 32'h8000_00A5);
    chk("ch2_valid", {28'd0, ov_a}, 32'h4);
    chk("ch2_data", {24'd0, data_a[23:16]}, 32'hA5);
    chk("ch2_last", {31'd0, last_a[2]}, 1);
    rd_chk(0, 32'h4000_0024, 32'h0000_0100, "status_ch2_lvl1");
    @(negedge clk); ordy_a[2] = 1'b1;
    @(negedge clk); ordy_a[2] = 1'b0;
    chk("ch2_drained", {31'd0, ov_a[2]}, 0);

    // Blocking on full: 16 words, then a stalled 17th
    for (int i = 0; i < 16; i++) wr(0, 32'h4000_0010, 32'(32'h30 + i));
    rd_chk(0, 32'h4000_0014, 32'h0000_1002, "status_ch1_full");
    @(negedge clk);
    addr = 32'h4000_0010; wdata = 32'h8000_0047; wstrb = 4'hF; valid_a = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (ready_a) seen = 1; end
    chk("stall_no_ready", seen, 0);
    chk("stall_head", {24'd0, data_a[15:8]}, 32'h30);
    ordy_a[1] = 1'b1;
    @(negedge clk); ordy_a[1] = 1'b0;
    k = 0;
    while (!ready_a && k < 20) begin @(negedge clk); k++; end
    chk("stall_released", {31'd0, ready_a}, 1);
    valid_a = 1'b0;
    $display("stalled write released after %0d extra cycles", k);
    rd_chk(0, 32'h4000_0014, 32'h0000_1002, "status_ch1_refull");
    @(negedge clk); ordy_a[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ch1_order", {24'd0, data_a[15:8]}, (i < 15) ? 32'(32'h31 + i) : 32'h47);
      chk("ch1_last", {31'd0, last_a[1]}, {31'd0, i == 15});
      @(negedge clk);
    end
    ordy_a[1] = 1'b0;
    chk("ch1_empty", {31'd0, ov_a[1]}, 0);

    // Dropping on full: overflow sticky, clear, flush
    for (int i = 0; i < 17; i++) wr(1, 32'h4000_0010, 32'(32'h50 + i));
    rd_chk(1, 32'h4000_0014, 32'h0000_1006, "status_ovf");
    wr(1, 32'h4000_0018, 32'h1);
    rd_chk(1, 32'h4000_0014, 32'h0000_1002, "status_ovf_clr");
    chk("b_head", {24'd0, data_b[15:8]}, 32'h50);
    wr(1, 32'h4000_0018, 32'h2);
    rd_chk(1, 32'h4000_0014, 32'h0000_0001, "status_flushed");
    chk("b_flush_valid", {28'd0, ov_b}, 0);

    // Concurrent channels 0 and 3 with a random consumer
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] rd;
      bus(0, 32'h4000_0000, {(i == 5), 23'd0, 8'(8'h10 + i)}, 4'h1, rd);
      bus(0, 32'h4000_0030, {(i == 5), 23'd0, 8'(8'hC0 + i)}, 4'h8, rd);
    end
    for (k = 0; k < 300 && !(got0 == 6 && got3 == 6); k++) @(negedge clk);
    mon_en = 1'b0;
    ordy_a = 4'b0;
    chk("ch0_count", got0, 6);
    chk("ch3_count", got3, 6);
    @(negedge clk);
    chk("all_drained", {28'd0, ov_a}, 0);

    // Just past the window: no hit, no response
    @(negedge clk);
    addr = 32'h4000_0040; wstrb = 4'h0; valid_a = 1'b1;
    #1 chk("miss_hit", {31'd0, hit_a}, 0);
    seen = 0;
    repeat (4) begin @(negedge clk); if (ready_a) seen = 1; end
    valid_a = 1'b0;
    chk("miss_no_ready", seen, 0);

    // Reset while stalled in WAIT_SPACE
    for (int i = 0; i < 16; i++) wr(0, 32'h4000_0020, 32'(32'h70 + i));
    @(negedge clk);
    addr = 32'h4000_0020; wdata = 32'h77; wstrb = 4'hF; valid_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", {31'd0, ov_a[2]}, 1);
    #2 resetn = 1'b0;
    #1 chk("async_rst_valid", {28'd0, ov_a}, 0);
    chk("async_rst_ready", {31'd0, ready_a}, 0);
    valid_a = 1'b0;
    @(negedge clk); resetn = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (ready_a) seen = 1; end
    chk("post_rst_no_ready", seen, 0);
    rd_chk(0, 32'h4000_0024, 32'h0000_0001, "status_ch2_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_stream_bridge.md
Name: mmio_stream_bridge

Overview:
- Memory-mapped slave on the picorv32 native bus (mem_valid/mem_ready handshake).
- Provides N_CHAN independent buffered output streams with last-of-packet marking. Replaces the ad-hoc single-cycle out_byte / out_matrix strobes.
- Each channel has a FIFO drained by a valid/ready consumer (LED driver, matrix engine, UART).
- Sits beside on-chip RAM in the system top. The top muxes mem_ready/mem_rdata by the hit output.

Parameters:
- N_CHAN, 4, number of output stream channels (1..8)
- DATA_W, 8, payload width per channel (1..31)
- DEPTH, 16, FIFO entries per channel (power of two, >=2)
- BASE_ADDR, 32'h4000_0000, base of the window; 256-byte aligned
- BLOCK_ON_FULL, 1, 1 = stall bus on full FIFO; 0 = drop write and set sticky overflow

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  CPU request valid
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- hit  out  1  combinational: mem_valid and address inside [BASE_ADDR, BASE_ADDR+N_CHAN*16)
- mem_ready  out  1  one-cycle response pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- out_data  out  N_CHAN*DATA_W  per-channel payload, channel c at [c*DATA_W +: DATA_W]
- out_last  out  N_CHAN  per-channel end-of-packet flag
- out_valid  out  N_CHAN  per-channel valid
- out_ready  in  N_CHAN  per-channel consumer ready

Behaviour:
Reset:
- Asynchronous reset on resetn low.
- mem_ready=0 and mem_rdata=0.
- All FIFOs empty; out_valid=0, out_data=0, out_last=0.
- Overflow flags cleared; FSM in IDLE.
- Reset mid-transaction aborts it with no response.

Address map, channel c, offsets from BASE_ADDR + c*16:
- 0x0 DATA (write): push {wdata[31] as last, wdata[DATA_W-1:0]}.
- 0x4 STATUS (read): bit0 empty, bit1 full, bit2 overflow_sticky, bits[15:8] level (zero-extended), rest 0.
- 0x8 CTRL (write): bit0=1 clears overflow_sticky; bit1=1 flushes the FIFO.
- Unused offsets inside the window: reads return 0, writes are ignored; both still get mem_ready.
- Address bits[1:0] ignored. Any nonzero mem_wstrb counts as a full-word write.

FSM, states IDLE / WAIT_SPACE / RESP:
- IDLE: on hit and mem_ready=0, decode.
  - Read, or write not to a full DATA register → perform action, go to RESP.
  - Write to DATA of a full channel with BLOCK_ON_FULL=1 → WAIT_SPACE.
  - Same with BLOCK_ON_FULL=0 → drop, set overflow_sticky, go to RESP.
- WAIT_SPACE: when the channel is not full (including a pop this cycle), push, go to RESP. mem_valid is guaranteed held by the CPU.
- RESP: mem_ready=1 for exactly one cycle, mem_rdata registered, then IDLE.
- Minimum latency: mem_ready 2 cycles after mem_valid rises.

FIFO:
- Per channel, first-word-fall-through.
- out_valid = not empty; a pop occurs when out_valid and out_ready.
- Push and pop in the same cycle with the FIFO full: allowed only via the WAIT_SPACE path; level stays DEPTH.
- Push and pop in the same cycle with the FIFO empty: the word appears on out_valid the next cycle (no bypass).
- Pointers wrap modulo DEPTH. Level is log2(DEPTH)+1 bits.
- Flush empties the FIFO the cycle after the write; a concurrent pop is ignored.
- STATUS read returns the level sampled in the decode cycle.

Decomposition:
- Package mmio_stream_pkg: register offsets (OFS_DATA=0, OFS_STATUS=4, OFS_CTRL=8), STATUS bit positions, CTRL bit positions, FSM state encoding.
- Sub-module stream_fifo:
  - Parameters: DATA_W+1 width, DEPTH.
  - Ports: push, pop, flush, full, empty, level.
  - Asynchronous active-low reset.
  - Instantiated N_CHAN times via generate.

Test Plan:
- Reset then read STATUS ch0 (addr 0x4000_0004) → rdata=0x0000_0001, mem_ready exactly 1 cycle, 2 cycles after mem_valid.
- Write 0x8000_00A5 to ch2 DATA (0x4000_0020) with out_ready[2]=0 → out_valid[2]=1, out_data[23:16]=0xA5, out_last[2]=1; STATUS ch2 level=1; assert out_ready → out_valid drops next cycle.
- BLOCK_ON_FULL=1: push 16 words to ch1, 17th write stalls (mem_ready stays 0); pulse out_ready[1] for 1 cycle → 17th completes, level=16, order preserved.
- BLOCK_ON_FULL=0: 17th write to ch1 → mem_ready after 2 cycles, STATUS=0x0000_1006; write CTRL 0x1 → overflow bit cleared.
- Channels 0 and 3 filled concurrently with independent random out_ready → each stream matches its write order, no cross-channel leakage; address 0x4000_0040 (N_CHAN=4) → hit=0, no mem_ready.
- Assert resetn low while in WAIT_SPACE → all out_valid=0 immediately, no mem_ready after release, STATUS reads empty.
